// File: rtl/conv55_sched.sv
// Scheduler for a 5x5 binary conv unit. It walks output pixels in row-major order,
// requests one window per input channel, accumulates the channel results and thresholds each pixel sum.
module conv55_sched #(
  parameter int CIN_MAX = 16,
  parameter int DIM_W   = 8,
  parameter int ACC_W   = 32,
  localparam int CW     = $clog2(CIN_MAX + 1),
  localparam int CHW    = (CIN_MAX > 1) ? $clog2(CIN_MAX) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [DIM_W-1:0] cfg_out_w_i,
  input  logic [DIM_W-1:0] cfg_out_h_i,
  input  logic [CW-1:0]    cfg_cin_i,
  input  logic [ACC_W-1:0] cfg_thr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o,
  output logic             win_req_valid_o,
  input  logic             win_req_ready_i,
  output logic [DIM_W-1:0] win_row_o,
  output logic [DIM_W-1:0] win_col_o,
  output logic [CHW-1:0]   win_ch_o,
  input  logic             conv_ovalid_i,
  input  logic [31:0]      conv_dout_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_sum_o,
  output logic             out_bit_o,
  output logic [DIM_W-1:0] out_row_o,
  output logic [DIM_W-1:0] out_col_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                  state_q;
  logic [DIM_W-1:0]        w_q, h_q, row_q, col_q, pix_row_q, pix_col_q, out_row_q, out_col_q;
  logic [CW-1:0]           cin_q;
  logic [CHW-1:0]          ch_q, rch_q;
  logic signed [ACC_W-1:0] thr_q, acc_q, out_sum_q;
  logic signed [ACC_W-1:0] acc_d;
  logic                    err_q, pend_q, out_valid_q, out_bit_q;
  logic                    cfg_ok, req_xfer, last_ch, last_col, last_row, res_en, res_last, out_acc;

  function automatic logic signed [ACC_W-1:0] sext_dout(input logic [31:0] d);
    return ACC_W'($signed(d));
  endfunction

  assign cfg_ok   = (cfg_out_w_i != '0) && (cfg_out_h_i != '0) &&
                    (cfg_cin_i != '0) && (cfg_cin_i <= CW'(CIN_MAX));
  assign last_ch  = (CW'(ch_q) == cin_q - CW'(1));
  assign last_col = (col_q == w_q - DIM_W'(1));
  assign last_row = (row_q == h_q - DIM_W'(1));
  assign res_last = (CW'(rch_q) == cin_q - CW'(1));

  // Issue stalls while a result is held or a pixel's last channel is still in flight,
  // so the result register is always free when a pixel completes.
  assign win_req_valid_o = (state_q == RUN) && !out_valid_q && !pend_q;
  assign req_xfer        = win_req_valid_o && win_req_ready_i;
  assign res_en          = conv_ovalid_i && ((state_q == RUN) || (state_q == DRAIN));
  assign out_acc         = out_valid_q && out_ready_i;
  assign acc_d           = ((rch_q == '0) ? '0 : acc_q) + sext_dout(conv_dout_i);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      cin_q       <= '0;
      thr_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ch_q        <= '0;
      rch_q       <= '0;
      pix_row_q   <= '0;
      pix_col_q   <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_bit_q   <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          w_q     <= cfg_out_w_i;
          h_q     <= cfg_out_h_i;
          cin_q   <= cfg_cin_i;
          thr_q   <= $signed(cfg_thr_i);
          row_q   <= '0;
          col_q   <= '0;
          ch_q    <= '0;
          rch_q   <= '0;
          pend_q  <= 1'b0;
          err_q   <= !cfg_ok;
          state_q <= cfg_ok ? RUN : DONE;
        end
        RUN: if (req_xfer) begin
          if (last_ch) begin
            ch_q      <= '0;
            pend_q    <= 1'b1;
            pix_row_q <= row_q;
            pix_col_q <= col_q;
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                row_q   <= '0;
                state_q <= DRAIN;
              end else begin
                row_q <= row_q + DIM_W'(1);
              end
            end else begin
              col_q <= col_q + DIM_W'(1);
            end
          end else begin
            ch_q <= ch_q + CHW'(1);
          end
        end
        DRAIN: if (out_acc) state_q <= DONE;
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (out_acc) out_valid_q <= 1'b0;

      // Result side: channel counter and accumulator, pixel result on the last channel
      if (res_en) begin
        acc_q <= acc_d;
        if (res_last) begin
          rch_q       <= '0;
          pend_q      <= 1'b0;
          out_valid_q <= 1'b1;
          out_sum_q   <= acc_d;
          out_bit_q   <= (acc_d >= thr_q);
          out_row_q   <= pix_row_q;
          out_col_q   <= pix_col_q;
        end else begin
          rch_q <= rch_q + CHW'(1);
        end
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign cfg_err_o   = (state_q == DONE) && err_q;
  assign win_row_o   = row_q;
  assign win_col_o   = col_q;
  assign win_ch_o    = ch_q;
  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign out_bit_o   = out_bit_q;
  assign out_row_o   = out_row_q;
  assign out_col_o   = out_col_q;

endmodule

// File: tb/tb_conv55_sched.sv
// Bench for conv55_sched: directed jobs plus randomized jobs, checked against a
// queue-based model of request order, per-pixel channel sums and thresholds.
`timescale 1ns/1ps
module tb_conv55_sched;
  localparam int CIN_MAX = 16;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [7:0]  cfg_w = '0, cfg_h = '0;
  logic [4:0]  cfg_cin = '0;
  logic [31:0] cfg_thr = '0;
  logic        busy, done, cfg_err, win_req_valid;
  logic        win_req_ready = 1'b0;
  logic [7:0]  win_row, win_col;
  logic [3:0]  win_ch;
  logic        conv_ovalid = 1'b0;
  logic [31:0] conv_dout = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_bit;
  logic [7:0]  out_row, out_col;

  conv55_sched #(.CIN_MAX(CIN_MAX), .DIM_W(8), .ACC_W(32)) dut (
    .clk(clk), .rstn(rstn), .start_i(start),
    .cfg_out_w_i(cfg_w), .cfg_out_h_i(cfg_h), .cfg_cin_i(cfg_cin), .cfg_thr_i(cfg_thr),
    .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err),
    .win_req_valid_o(win_req_valid), .win_req_ready_i(win_req_ready),
    .win_row_o(win_row), .win_col_o(win_col), .win_ch_o(win_ch),
    .conv_ovalid_i(conv_ovalid), .conv_dout_i(conv_dout),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_bit_o(out_bit), .out_row_o(out_row), .out_col_o(out_col)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct {int r; int c; int ch;} tup_t;
  typedef struct {int sum; bit b; int r; int c;} res_t;
  typedef struct {int due; int d;} cv_t;

  tup_t exp_req[$];
  res_t exp_res[$];
  cv_t  cq[$];
  int   fixed_d[$];
  logic [31:0] last_sum;
  logic        last_bit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, cfg_err, win_req_valid, out_valid, out_bit}, 64'd0);
    chk({tag, "_data"}, {out_sum, win_row, win_col, win_ch}, 64'd0);
    chk({tag, "_pos"}, {out_row, out_col}, 64'd0);
  endtask

  // One job: w x h pixels, cin channels, conv latency lat.
  // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random. omode: 0 ready high, 1 hold low 5 cycles, 2 random.
  task automatic run_job(input int w, input int h, input int cin, input int thr, input int lat,
                         input int rmode, input int omode, input int abort_at, input bit noise);
    int cyc = 0, pix_sum = 0, hold = 0, done_cnt = 0, nreq = 0, nres = 0;
    bit stall_prev = 0, resume_exp = 0, fin = 0;
    logic [19:0] prev_tup = '0;
    logic [48:0] snap = '0;
    exp_req.delete(); exp_res.delete(); cq.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        for (int ch = 0; ch < cin; ch++)
          exp_req.push_back('{r, c, ch});
    @(negedge clk);
    cfg_w = 8'(w); cfg_h = 8'(h); cfg_cin = 5'(cin); cfg_thr = thr;
    while (!fin && cyc < 3000) begin
      start = (cyc == 0);
      if (noise && cyc >= 2) begin
        start = 1'($urandom_range(0, 1));
        cfg_w = 8'($urandom); cfg_h = 8'($urandom); cfg_cin = 5'($urandom); cfg_thr = $urandom;
      end
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (stall_prev) begin
        chk("req_hold_valid", win_req_valid, 1);
        chk("req_hold_tuple", {win_row, win_col, win_ch}, prev_tup);
      end
      if (resume_exp) chk("issue_resume", win_req_valid, 1);
      resume_exp = 0;
      if (out_valid) chk("no_issue_while_out_valid", win_req_valid, 0);
      if (abort_at > 0 && cyc == abort_at) begin
        chk("busy_before_abort", busy, 1);
        #2 rstn = 1'b0;
        #1 chk_all_zero("rst_async");
        conv_ovalid = 1'b0; win_req_ready = 1'b0; out_ready = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("rst_no_done", {done, busy}, 0);
        @(negedge clk) rstn = 1'b1;
        return;
      end
      if (done) begin
        done_cnt++;
        chk("done_cfg_err", cfg_err, 0);
        chk("done_all_req", nreq, w * h * cin);
        chk("done_all_res", nres, w * h);
        fin = 1;
      end
      case (rmode)
        0: win_req_ready = 1'b1;
        1: win_req_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: win_req_ready = 1'($urandom_range(0, 1));
      endcase
      if (omode == 0) out_ready = 1'b1;
      else if (omode == 2) out_ready = 1'($urandom_range(0, 1));
      else if (!out_valid) out_ready = 1'b0;
      else begin
        if (hold == 0) snap = {out_sum, out_bit, out_row, out_col};
        else chk("out_hold_stable", {out_sum, out_bit, out_row, out_col}, snap);
        if (hold < 5) begin out_ready = 1'b0; hold++; end
        else begin out_ready = 1'b1; hold = 0; end
      end
      if (cq.size() > 0 && cq[0].due == cyc) begin
        conv_ovalid = 1'b1; conv_dout = cq[0].d; void'(cq.pop_front());
      end else begin
        conv_ovalid = 1'b0; conv_dout = $urandom;
      end
      if (win_req_valid && win_req_ready) begin
        tup_t t;
        int d;
        if (exp_req.size() == 0) chk("extra_request", 1, 0);
        else begin
          t = exp_req.pop_front();
          chk("req_tuple", {win_row, win_col, win_ch}, {8'(t.r), 8'(t.c), 4'(t.ch)});
          d = (fixed_d.size() > 0) ? fixed_d.pop_front() : int'($urandom);
          cq.push_back('{cyc + lat, d});
          pix_sum = (t.ch == 0) ? d : pix_sum + d;
          if (t.ch == cin - 1) exp_res.push_back('{pix_sum, (pix_sum >= thr), t.r, t.c});
          nreq++;
        end
        stall_prev = 0;
      end else begin
        stall_prev = win_req_valid;
        prev_tup = {win_row, win_col, win_ch};
      end
      if (out_valid && out_ready) begin
        res_t e;
        if (exp_res.size() == 0) chk("extra_result", 1, 0);
        else begin
          e = exp_res.pop_front();
          chk("out_sum", out_sum, $unsigned(e.sum));
          chk("out_bit", out_bit, e.b);
          chk("out_pos", {out_row, out_col}, {8'(e.r), 8'(e.c)});
        end
        last_sum = out_sum; last_bit = out_bit;
        nres++;
        resume_exp = (exp_req.size() > 0);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; conv_ovalid = 1'b0;
    chk("job_finished", fin, 1);
    chk("done_single_pulse", done_cnt, 1);
    chk("idle_after_done", {busy, done}, 0);
  endtask

  task automatic illegal_job(input int w, input int h, input int cin);
    @(negedge clk);
    cfg_w = 8'(w); cfg_h = 8'(h); cfg_cin = 5'(cin); start = 1'b1;
    win_req_ready = 1'b1; out_ready = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("illegal_done", {done, cfg_err, busy}, 3'b111);
    chk("illegal_no_req", win_req_valid, 0);
    @(negedge clk);
    chk("illegal_idle", {done, cfg_err, busy, win_req_valid}, 0);
  endtask

  initial begin
    #3 chk_all_zero("reset_state");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_job(2, 2, 1, 0, 1, 0, 0, 0, 0);

    fixed_d.push_back(10); fixed_d.push_back(-4); fixed_d.push_back(-7);
    run_job(1, 1, 3, 0, 1, 0, 0, 0, 0);
    chk("acc_sum_minus1", last_sum, 32'hFFFF_FFFF);
    chk("acc_bit_thr0", last_bit, 0);
    fixed_d.push_back(10); fixed_d.push_back(-4); fixed_d.push_back(-7);
    run_job(1, 1, 3, -1, 2, 0, 0, 0, 0);
    chk("acc_bit_thrm1", last_bit, 1);

    run_job(2, 3, 2, int'($urandom), 1, 0, 1, 0, 0);
    run_job(3, 2, 2, int'($urandom), 3, 1, 0, 0, 0);

    illegal_job(2, 2, 0);
    illegal_job(2, 2, CIN_MAX + 1);
    illegal_job(0, 2, 1);
    illegal_job(2, 0, 1);

    run_job(3, 3, 2, 0, 2, 0, 0, 6, 0);
    run_job(1, 1, 2, int'($urandom), 1, 0, 0, 0, 0);

    run_job(1, 2, CIN_MAX, 0, 2, 2, 2, 0, 1);
    for (int k = 0; k < 6; k++)
      run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), int'($urandom_range(1, CIN_MAX)),
              int'($urandom), int'($urandom_range(1, 4)), 2, int'($urandom_range(0, 2)), 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
